shift_sequencer: RTL and testbench

Command-driven controller for the 4-bit universal shift register.
- Accepts one command per valid/ready handshake: parallel load, multi-step shift, or rotate.
- Drives the register's mode selects and serial input for the required number of clocks, then reports completion.
- Sits between a requester (CPU-style driver or testbench) and the register, which it instantiates.

---
 rtl/shift_sequencer_pkg.sv | 33 +++
 rtl/shift_sequencer_uni_reg4.sv | 38 +++
 rtl/shift_sequencer.sv | 155 +++++++++++++++
 tb/tb_shift_sequencer.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/shift_sequencer_pkg.sv
// Shared types for shift_sequencer: op codes, FSM states, register mode selects.
// SHIFT_SEQUENCER_ROTATE_EN enables the ROL/ROR op codes.
package shift_sequencer_pkg;

  typedef enum logic [2:0] {
    LOAD = 3'b000,
    SHL  = 3'b001,
    SHR  = 3'b010,
    ROL  = 3'b011,
    ROR  = 3'b100
  } op_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_e;

  localparam logic [1:0] MODE_HOLD = 2'b00;
  localparam logic [1:0] MODE_SHR  = 2'b01;
  localparam logic [1:0] MODE_SHL  = 2'b10;
  localparam logic [1:0] MODE_LOAD = 2'b11;

  // Rotates only count as legal when their feedback path is built.
  function automatic logic op_legal(input logic [2:0] op);
`ifdef SHIFT_SEQUENCER_ROTATE_EN
    return (op <= 3'd4);
`else
    return (op <= 3'd2);
`endif
  endfunction

endpackage

// File: rtl/shift_sequencer_uni_reg4.sv
// 4-bit universal register: hold, shift right, shift left or parallel load,
// selected by mode {l,r}; asynchronous active-low reset to zero.
module uni_reg4
  import shift_sequencer_pkg::*;
(
  input  logic       clk,
  input  logic       nrst,
  input  logic [1:0] mode,
  input  logic       i,
  input  logic [3:0] d,
  output logic [3:0] q
);

  logic [3:0] q_q;
  logic [3:0] q_d;

  always_comb begin
    q_d = q_q;
    case (mode)
      MODE_HOLD: q_d = q_q;
      MODE_SHR:  q_d = {i, q_q[3:1]};
      MODE_SHL:  q_d = {q_q[2:0], i};
      MODE_LOAD: q_d = d;
      default:   q_d = q_q;
    endcase
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      q_q <= 4'b0000;
    end else begin
      q_q <= q_d;
    end
  end

  assign q = q_q;

endmodule

// File: rtl/shift_sequencer.sv
// Command sequencer for a 4-bit universal register: LOAD / SHL / SHR / ROL / ROR.
// Rotates are built only when SHIFT_SEQUENCER_ROTATE_EN is defined.
module shift_sequencer
  import shift_sequencer_pkg::*;
(
  input  logic       clk,
  input  logic       nrst,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [2:0] cmd_op,
  input  logic [1:0] cmd_cnt,
  input  logic [3:0] cmd_data,
  input  logic       sin,
  output logic [3:0] q,
  output logic       sout,
  output logic       busy,
  output logic       done,
  output logic       err,
  output logic [1:0] dbg_state
);

  // Handshake: a command is taken on a rising edge where cmd_valid && cmd_ready;
  // cmd_ready is high only in IDLE, so cmd_* are don't-care at all other times.

  state_e     state_q, state_d;
  op_e        op_q, op_d;
  logic [1:0] cnt_q, cnt_d;
  logic [1:0] step_q, step_d;
  logic [3:0] data_q, data_d;
  logic       sout_q, sout_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic       err_q, err_d;

  logic [1:0] mode;
  logic       ser_in;
  logic       shift_out;

  // Register drive is only non-hold while RUN; everything else leaves q alone.
  always_comb begin
    mode      = MODE_HOLD;
    ser_in    = 1'b0;
    shift_out = sout_q;
    if (state_q == RUN) begin
      case (op_q)
        LOAD: mode = MODE_LOAD;
        SHL: begin
          mode      = MODE_SHL;
          ser_in    = sin;
          shift_out = q[3];
        end
        SHR: begin
          mode      = MODE_SHR;
          ser_in    = sin;
          shift_out = q[0];
        end
`ifdef SHIFT_SEQUENCER_ROTATE_EN
        ROL: begin
          mode      = MODE_SHL;
          ser_in    = q[3];
          shift_out = q[3];
        end
        ROR: begin
          mode      = MODE_SHR;
          ser_in    = q[0];
          shift_out = q[0];
        end
`endif
        default: mode = MODE_HOLD;
      endcase
    end
  end

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    cnt_d   = cnt_q;
    step_d  = step_q;
    data_d  = data_q;
    sout_d  = sout_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          op_d   = op_e'(cmd_op);
          cnt_d  = (cmd_op == LOAD) ? 2'd0 : cmd_cnt;
          data_d = cmd_data;
          step_d = 2'd0;
          if (op_legal(cmd_op)) begin
            state_d = RUN;
            busy_d  = 1'b1;
          end else begin
            state_d = DONE;
            done_d  = 1'b1;
            err_d   = 1'b1;
          end
        end
      end
      RUN: begin
        sout_d = shift_out;
        step_d = step_q + 2'd1;
        if (step_q == cnt_q) begin
          state_d = DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q <= IDLE;
      op_q    <= LOAD;
      cnt_q   <= 2'd0;
      step_q  <= 2'd0;
      data_q  <= 4'b0000;
      sout_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      cnt_q   <= cnt_d;
      step_q  <= step_d;
      data_q  <= data_d;
      sout_q  <= sout_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  uni_reg4 u_reg (
    .clk  (clk),
    .nrst (nrst),
    .mode (mode),
    .i    (ser_in),
    .d    (data_q),
    .q    (q)
  );

  assign cmd_ready = (state_q == IDLE);
  assign sout      = sout_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign err       = err_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_shift_sequencer.sv
// Self-checking bench for shift_sequencer: reference model feeds a result
// queue that is drained on every done pulse.
`timescale 1ns/1ps
module tb_shift_sequencer;
  import shift_sequencer_pkg::*;

  logic       clk = 1'b0;
  logic       nrst = 1'b0;
  logic       cmd_valid = 1'b0;
  logic [2:0] cmd_op = 3'd0;
  logic [1:0] cmd_cnt = 2'd0;
  logic [3:0] cmd_data = 4'd0;
  logic       sin = 1'b0;
  logic       cmd_ready;
  logic [3:0] q;
  logic       sout, busy, done, err;
  logic [1:0] dbg_state;

`ifdef SHIFT_SEQUENCER_ROTATE_EN
  localparam bit ROT = 1'b1;
`else
  localparam bit ROT = 1'b0;
`endif

  int checks = 0;
  int failures = 0;
  logic [5:0] exp_q[$];
  logic [5:0] mon_e;
  logic [3:0] m_q;
  logic       m_sout;
  logic [3:0] step_exp [1:4];

  shift_sequencer dut (
    .clk       (clk),
    .nrst      (nrst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_cnt   (cmd_cnt),
    .cmd_data  (cmd_data),
    .sin       (sin),
    .q         (q),
    .sout      (sout),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .dbg_state (dbg_state)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Every done pulse must match the oldest outstanding result {err,sout,q}.
  always @(negedge clk) begin
    if (nrst && done) begin
      if (exp_q.size() == 0) begin
        check("unexpected_done", 32'd1, 32'd0);
      end else begin
        mon_e = exp_q.pop_front();
        check("result", {26'd0, err, sout, q}, {26'd0, mon_e});
      end
    end
  end

  // Call at a negedge. Leaves the bench at a negedge with cmd_ready high.
  task automatic do_cmd(input logic [2:0] op, input logic [1:0] cnt,
                        input logic [3:0] data, input logic [3:0] bits,
                        input bit keep_valid);
    bit accepted, legal, finished;
    int n, busy_cnt, rdy_low, done_cnt;
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_cnt   = cnt;
    cmd_data  = data;
    sin       = bits[0];
    accepted  = 1'b0;
    for (int w = 0; w < 20; w++) begin
      if (cmd_ready) begin
        accepted = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!accepted) begin
      check("accept_timeout", 32'd0, 32'd1);
      cmd_valid = 1'b0;
      return;
    end
    legal = (op <= 3'd2) || (ROT && op <= 3'd4);
    n = (op == 3'd0) ? 1 : int'(cnt) + 1;
    for (int j = 1; j <= 4; j++) step_exp[j] = m_q;
    if (legal) begin
      for (int j = 0; j < n; j++) begin
        case (op)
          3'd0: m_q = data;
          3'd1: begin m_sout = m_q[3]; m_q = {m_q[2:0], bits[j]}; end
          3'd2: begin m_sout = m_q[0]; m_q = {bits[j], m_q[3:1]}; end
          3'd3: begin m_sout = m_q[3]; m_q = {m_q[2:0], m_q[3]}; end
          default: begin m_sout = m_q[0]; m_q = {m_q[0], m_q[3:1]}; end
        endcase
        step_exp[j+1] = m_q;
      end
    end
    exp_q.push_back({~legal, m_sout, m_q});
    @(posedge clk);
    #1;
    if (keep_valid) begin
      cmd_op   = 3'($urandom);
      cmd_cnt  = 2'($urandom);
      cmd_data = 4'($urandom);
    end else begin
      cmd_valid = 1'b0;
    end
    busy_cnt = 0;
    rdy_low  = 0;
    done_cnt = 0;
    finished = 1'b0;
    for (int t = 0; t < 12; t++) begin
      @(negedge clk);
      if (cmd_ready) begin
        finished = 1'b1;
        break;
      end
      busy_cnt += int'(busy);
      rdy_low++;
      done_cnt += int'(done);
      if (legal && t >= 1 && t <= n) check("step_q", {28'd0, q}, {28'd0, step_exp[t]});
      if (t < 4) sin = bits[t];
    end
    check("ready_return", {31'd0, finished}, 32'd1);
    check("busy_cycles", busy_cnt, legal ? n : 0);
    check("ready_low_cycles", rdy_low, legal ? n + 1 : 1);
    check("done_pulses", done_cnt, 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    m_q    = 4'd0;
    m_sout = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_q", {28'd0, q}, 32'd0);
    check("rst_sout", {31'd0, sout}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_err", {31'd0, err}, 32'd0);
    check("rst_ready", {31'd0, cmd_ready}, 32'd1);
    check("rst_state", {30'd0, dbg_state}, {30'd0, IDLE});
    nrst = 1'b1;
    @(negedge clk);

    do_cmd(3'b000, 2'd2, 4'b1010, 4'b0000, 1'b0);
    do_cmd(3'b001, 2'd1, 4'b0000, 4'b0001, 1'b0);
    do_cmd(3'b000, 2'd0, 4'b0001, 4'b0000, 1'b0);
    do_cmd(3'b100, 2'd0, 4'b0000, 4'b0000, 1'b0);
    do_cmd(3'b000, 2'd0, 4'b1011, 4'b0000, 1'b0);
    do_cmd(3'b011, 2'd3, 4'b0000, 4'b0000, 1'b0);
    do_cmd(3'b110, 2'd2, 4'b1111, 4'b1111, 1'b0);

    // Reset in the middle of a 4-step SHR.
    do_cmd(3'b000, 2'd0, 4'b1111, 4'b0000, 1'b0);
    cmd_valid = 1'b1;
    cmd_op    = 3'b010;
    cmd_cnt   = 2'd3;
    sin       = 1'b0;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    check("midrun_busy", {31'd0, busy}, 32'd1);
    @(posedge clk);
    @(posedge clk);
    #1;
    check("pre_reset_q", {28'd0, q}, 32'h3);
    nrst = 1'b0;
    #1;
    check("mid_rst_q", {28'd0, q}, 32'd0);
    check("mid_rst_sout", {31'd0, sout}, 32'd0);
    check("mid_rst_busy", {31'd0, busy}, 32'd0);
    check("mid_rst_done", {31'd0, done}, 32'd0);
    check("mid_rst_state", {30'd0, dbg_state}, {30'd0, IDLE});
    check("mid_rst_ready", {31'd0, cmd_ready}, 32'd1);
    m_q    = 4'd0;
    m_sout = 1'b0;
    @(negedge clk);
    nrst = 1'b1;
    repeat (3) @(negedge clk);

    // Back-to-back with cmd_valid held high across both commands.
    do_cmd(3'b000, 2'd0, 4'b0110, 4'b0000, 1'b1);
    do_cmd(3'b010, 2'd0, 4'b0000, 4'b0001, 1'b0);
    check("queued_q", {28'd0, q}, 32'hB);
    check("queued_sout", {31'd0, sout}, 32'd0);

    for (int i = 0; i < 12; i++) begin
      do_cmd(3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)),
             4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
             (i < 11) ? 1'($urandom_range(0, 1)) : 1'b0);
    end

    repeat (4) @(negedge clk);
    check("queue_empty", exp_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
